core_seq: RTL and testbench



---
 rtl/core_seq.sv | 199 +++++++++++++++++++
 tb/tb_core_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq.sv
// core_seq: multicycle one-hot instruction sequencer with req/ack instruction and data memory ports.
// Defining PERF_COUNTERS_EN adds free-running cycles/retired counter outputs.
module core_seq #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              INST_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              RA_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] dec_inst,
  output logic [PC_W-1:0]   dec_pc,
  input  logic [4:0]        dec_cls,
  input  logic              dec_store,
  input  logic [RA_W-1:0]   dec_rd,
  input  logic [DATA_W-1:0] dec_val,
  input  logic [DATA_W-1:0] dec_addr,
  input  logic [PC_W-1:0]   dec_target,
  input  logic              dec_taken,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              halt_req,
  output logic              halted,
  output logic              trap,
  output logic [PC_W-1:0]   trap_pc,
  output logic [7:0]        state
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0]       cycles,
  output logic [31:0]       retired
`endif
);

  localparam logic [7:0] S_FETCH = 8'h01;
  localparam logic [7:0] S_FWAIT = 8'h02;
  localparam logic [7:0] S_DEC   = 8'h04;
  localparam logic [7:0] S_EXE   = 8'h08;
  localparam logic [7:0] S_XWAIT = 8'h10;
  localparam logic [7:0] S_WRITE = 8'h20;
  localparam logic [7:0] S_HALT  = 8'h40;
  localparam logic [7:0] S_TRAP  = 8'h80;

  // class one-hot bit positions: {subst,jump,branch,mem,alu}
  localparam int C_MEM = 1;
  localparam int C_BR  = 2;
  localparam int C_JMP = 3;

  logic [7:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_q, npc_q, dec_pc_q, tgt_q, trap_pc_q;
  logic [INST_W-1:0] inst_q;
  logic [4:0]        cls_q;
  logic              store_q, taken_q, wpend_q, rf_we_q;
  logic [RA_W-1:0]   rd_q, rf_waddr_q;
  logic [DATA_W-1:0] val_q, addr_q, wdat_q, rf_wdata_q;

  logic [PC_W-1:0]   pc4, ex_npc;
  logic [DATA_W-1:0] ex_wdat;
  logic              ex_wpend, cls_ok, ex_trap, mem_go, dmem_vis, fetch_vis;

  always_comb begin
    pc4      = dec_pc_q + PC_W'(4);
    ex_npc   = pc4;
    ex_wdat  = val_q;
    ex_wpend = 1'b0;
    if (cls_q[C_JMP]) begin
      ex_npc   = tgt_q;
      ex_wdat  = DATA_W'(pc4);
      ex_wpend = 1'b1;
    end else if (cls_q[C_BR]) begin
      ex_npc = taken_q ? tgt_q : pc4;
    end else if (cls_q[C_MEM]) begin
      ex_wpend = !store_q;
    end else begin
      ex_wpend = 1'b1;
    end
    cls_ok  = (cls_q != 5'd0) && ((cls_q & (cls_q - 5'd1)) == 5'd0);
    ex_trap = !cls_ok || (ex_npc[1:0] != 2'b00);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_FWAIT;
      S_FWAIT: if (imem_ack) state_d = S_DEC;
      S_DEC:   state_d = S_EXE;
      S_EXE:   state_d = ex_trap ? S_TRAP : (cls_q[C_MEM] ? S_XWAIT : S_WRITE);
      S_XWAIT: if (dmem_ack) state_d = S_WRITE;
      S_WRITE: state_d = halt_req ? S_HALT : S_FETCH;
      S_HALT:  if (!halt_req) state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset parks the FSM in FETCH, so the fetch outputs are masked while rst is held.
  assign fetch_vis = ((state_q == S_FETCH) || (state_q == S_FWAIT)) && !rst;
  assign imem_req  = (state_q == S_FETCH) && !rst;
  assign imem_addr = fetch_vis ? pc_q : '0;

  assign mem_go     = (state_q == S_EXE) && cls_q[C_MEM] && !ex_trap;
  assign dmem_vis   = mem_go || (state_q == S_XWAIT);
  assign dmem_req   = mem_go;
  assign dmem_we    = dmem_vis && store_q;
  assign dmem_addr  = dmem_vis ? addr_q : '0;
  assign dmem_wdata = dmem_vis ? val_q : '0;

  assign dec_inst = inst_q;
  assign dec_pc   = dec_pc_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign halted   = (state_q == S_HALT);
  assign trap     = (state_q == S_TRAP);
  assign trap_pc  = trap_pc_q;
  assign state    = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      npc_q      <= '0;
      inst_q     <= '0;
      dec_pc_q   <= '0;
      cls_q      <= '0;
      store_q    <= 1'b0;
      rd_q       <= '0;
      val_q      <= '0;
      addr_q     <= '0;
      tgt_q      <= '0;
      taken_q    <= 1'b0;
      wdat_q     <= '0;
      wpend_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      trap_pc_q  <= '0;
    end else begin
      state_q <= state_d;
      rf_we_q <= 1'b0;
      case (state_q)
        S_FWAIT: if (imem_ack) begin
          inst_q   <= imem_data;
          dec_pc_q <= pc_q;
        end
        S_DEC: begin
          cls_q   <= dec_cls;
          store_q <= dec_store;
          rd_q    <= dec_rd;
          val_q   <= dec_val;
          addr_q  <= dec_addr;
          tgt_q   <= dec_target;
          taken_q <= dec_taken;
        end
        S_EXE: begin
          npc_q   <= ex_npc;
          wdat_q  <= ex_wdat;
          wpend_q <= ex_wpend && !ex_trap;
          if (ex_trap) trap_pc_q <= dec_pc_q;
        end
        S_XWAIT: if (dmem_ack && !store_q) wdat_q <= dmem_rdata;
        S_WRITE: begin
          pc_q       <= npc_q;
          rf_we_q    <= wpend_q && (rd_q != '0);
          rf_waddr_q <= rd_q;
          rf_wdata_q <= wdat_q;
        end
        default: ;
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [31:0] cyc_q, ret_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (state_q == S_WRITE) ret_q <= ret_q + 32'd1;
    end
  end
  assign cycles  = cyc_q;
  assign retired = ret_q;
`endif

endmodule

// File: tb/tb_core_seq.sv
// Table-driven bench for core_seq: the bench plays instruction memory, data memory and decoder.
module tb_core_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data, dec_inst, dec_pc;
  logic [4:0]  dec_cls, dec_rd, rf_waddr;
  logic        dec_store, dec_taken;
  logic [31:0] dec_val, dec_addr, dec_target;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, rf_wdata, trap_pc;
  logic        rf_we, halt_req, halted, trap;
  logic [7:0]  state;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycles, retired;
`endif

  always #5 clk = ~clk;

  core_seq dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dec_inst(dec_inst), .dec_pc(dec_pc),
    .dec_cls(dec_cls), .dec_store(dec_store), .dec_rd(dec_rd), .dec_val(dec_val),
    .dec_addr(dec_addr), .dec_target(dec_target), .dec_taken(dec_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .halt_req(halt_req), .halted(halted), .trap(trap), .trap_pc(trap_pc), .state(state)
`ifdef PERF_COUNTERS_EN
    , .cycles(cycles), .retired(retired)
`endif
  );

  typedef struct {
    logic [4:0]  cls;
    logic        st;
    logic [4:0]  rd;
    logic [31:0] val, addr, tgt;
    logic        tk;
    logic [31:0] rdata;
    int          dly;
    logic [31:0] npc;
    logic        we;
    logic [31:0] wd;
    int          lat;
  } vec_t;

  vec_t vt [16];

  // Decoder model: the instruction word is just an index into the vector table.
  assign dec_cls    = vt[dec_inst[3:0]].cls;
  assign dec_store  = vt[dec_inst[3:0]].st;
  assign dec_rd     = vt[dec_inst[3:0]].rd;
  assign dec_val    = vt[dec_inst[3:0]].val;
  assign dec_addr   = vt[dec_inst[3:0]].addr;
  assign dec_target = vt[dec_inst[3:0]].tgt;
  assign dec_taken  = vt[dec_inst[3:0]].tk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] cls, input logic st, input logic [4:0] rd,
                              input logic [31:0] val, input logic [31:0] addr, input logic [31:0] tgt,
                              input logic tk, input logic [31:0] rdata, input int dly,
                              input logic [31:0] npc, input logic we, input logic [31:0] wd, input int lat);
    vec_t v;
    v.cls = cls; v.st = st; v.rd = rd; v.val = val; v.addr = addr; v.tgt = tgt; v.tk = tk;
    v.rdata = rdata; v.dly = dly; v.npc = npc; v.we = we; v.wd = wd; v.lat = lat;
    return v;
  endfunction

  // Entered at a negedge with imem_req high; returns at the next fetch, halt or trap.
  task automatic run_insn(input int i, input logic [31:0] pc, input int halt_at);
    int c, ackc, nreq, nwe;
    logic [31:0] wa, wd;
    logic done;
    vec_t v;
    v = vt[i];
    chk($sformatf("v%0d imem_addr", i), imem_addr, pc);
    c = 0; ackc = -1; nreq = 0; nwe = 0; wa = 0; wd = 0; done = 1'b0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      imem_ack  = (c == 1);
      imem_data = i;
      if (c == halt_at) halt_req = 1'b1;
      if (c == 1) chk($sformatf("v%0d imem_req pulse", i), {31'd0, imem_req}, 32'd0);
      dmem_ack   = (c == ackc);
      dmem_rdata = v.rdata;
      if (c == ackc) chk($sformatf("v%0d dmem_addr held", i), dmem_addr, v.addr);
      if (dmem_req) begin
        nreq++;
        if (nreq == 1) begin
          ackc = c + v.dly;
          chk($sformatf("v%0d dmem_we", i), {31'd0, dmem_we}, {31'd0, v.st});
          chk($sformatf("v%0d dmem_addr", i), dmem_addr, v.addr);
          chk($sformatf("v%0d dmem_wdata", i), dmem_wdata, v.val);
        end
      end
      if (rf_we) begin
        nwe++; wa = {27'd0, rf_waddr}; wd = rf_wdata;
      end
      done = (c > 1) && (imem_req || halted || trap);
    end
    dmem_ack = 1'b0;
    chk($sformatf("v%0d latency", i), c, v.lat);
    chk($sformatf("v%0d dmem_req count", i), nreq, (v.cls == 5'b00010) ? 1 : 0);
    chk($sformatf("v%0d rf_we count", i), nwe, v.we ? 1 : 0);
    if (v.we) begin
      chk($sformatf("v%0d rf_waddr", i), wa, {27'd0, v.rd});
      chk($sformatf("v%0d rf_wdata", i), wd, v.wd);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; halt_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    int n;
    rst = 1'b1; halt_req = 1'b0; imem_ack = 1'b0; imem_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    for (int k = 0; k < 16; k++) vt[k] = mk(5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    //            cls        st rd  val          addr   tgt           tk rdata         dly npc           we wd           lat
    vt[0]  = mk(5'b00001, 0, 3,  32'h5,       0,     0,            0, 0,            0, 32'h4,        1, 32'h5,        5);
    vt[1]  = mk(5'b00010, 0, 7,  0,           32'h40, 0,           0, 32'hDEADBEEF, 4, 32'h8,        1, 32'hDEADBEEF, 9);
    vt[2]  = mk(5'b00010, 1, 9,  32'h1234,    32'h80, 0,           0, 32'h5555,     1, 32'hC,        0, 0,            6);
    vt[3]  = mk(5'b00100, 0, 0,  0,           0,     32'h100,      1, 0,            0, 32'h100,      0, 0,            5);
    vt[4]  = mk(5'b10000, 0, 31, 32'hA5A5,    0,     0,            0, 0,            0, 32'h104,      1, 32'hA5A5,     5);
    vt[5]  = mk(5'b01000, 0, 0,  0,           0,     32'hFFFFFFFC, 0, 0,            0, 32'hFFFFFFFC, 0, 0,            5);
    vt[6]  = mk(5'b00100, 0, 0,  0,           0,     32'h200,      0, 0,            0, 32'h0,        0, 0,            5);
    vt[7]  = mk(5'b01000, 0, 1,  0,           0,     32'h20,       0, 0,            0, 32'h20,       1, 32'h4,        5);
    vt[8]  = mk(5'b00001, 0, 0,  32'h77,      0,     0,            0, 0,            0, 32'h24,       0, 0,            5);
    vt[9]  = mk(5'b01000, 0, 5,  0,           0,     32'h102,      0, 0,            0, 0,            0, 0,            4);
    vt[10] = mk(5'b00011, 0, 2,  32'h9,       32'h44, 0,           0, 0,            1, 0,            0, 0,            4);

    repeat (2) @(negedge clk);
    chk("rst imem_req", {31'd0, imem_req}, 0);
    chk("rst imem_addr", imem_addr, 0);
    chk("rst dmem_req", {31'd0, dmem_req}, 0);
    chk("rst dmem_addr", dmem_addr, 0);
    chk("rst rf_we", {31'd0, rf_we}, 0);
    chk("rst halted", {31'd0, halted}, 0);
    chk("rst trap", {31'd0, trap}, 0);
    chk("rst trap_pc", trap_pc, 0);
    chk("rst dec_pc", dec_pc, 0);
    chk("rst state", {24'd0, state}, 32'h1);
    rst = 1'b0;
    #1;
    chk("fetch after reset", {31'd0, imem_req}, 1);

    pc = 32'h0;
    for (int i = 0; i < 10; i++) begin
      run_insn(i, pc, -1);
      pc = vt[i].npc;
    end
    chk("jump trap flag", {31'd0, trap}, 1);
    chk("jump trap_pc", trap_pc, 32'h24);
    chk("trap state", {24'd0, state}, 32'h80);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req || !trap) n++;
    end
    chk("trap sticky no fetch", n, 0);

    do_reset();
    chk("post-trap reset trap", {31'd0, trap}, 0);
    run_insn(0, 32'h0, -1);
    run_insn(10, 32'h4, -1);
    chk("bad cls trap", {31'd0, trap}, 1);
    chk("bad cls trap_pc", trap_pc, 32'h4);

    do_reset();
    run_insn(0, 32'h0, 2);
    chk("halt flag", {31'd0, halted}, 1);
    chk("halt state", {24'd0, state}, 32'h40);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (imem_req || !halted) n++;
    end
    chk("halt hold no fetch", n, 0);
    halt_req = 1'b0;
    n = 0;
    while (!imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("resume fetch", {31'd0, imem_req}, 1);
    chk("resume imem_addr", imem_addr, 32'h4);

`ifdef PERF_COUNTERS_EN
    do_reset();
    run_insn(0, 32'h0, -1);
    run_insn(0, 32'h4, -1);
    run_insn(0, 32'h8, -1);
    chk("perf retired", retired, 3);
    chk("perf cycles", cycles, 15);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
    $fatal(1);
  end
endmodule
